serial_addsub32: RTL

Bit-serial two's-complement adder/subtractor for the floating-point datapath. It reuses the single full-adder equation, one bit per clock, LSB first, over WIDTH cycles. It is the subtract-capable, sequential counterpart to the combinational full adder and serves the mantissa add/subtract and exponent-difference paths where area matters more than latency. Operation uses a start/busy/done handshake, and the result is held until the next operation completes.

---
 rtl/serial_addsub32_if.sv | 42 ++++
 rtl/serial_addsub32.sv | 100 ++++++++++
 2 files changed

// File: rtl/serial_addsub32_if.sv
// -----------------------------------------------------------------------------
// serial_addsub32_if
//
// Handshake and data bundle for the bit-serial adder/subtractor.
//
// Signals
//   start  request a new operation; honoured only when the unit is not running
//   sub    0: A+B, 1: A-B (captured together with start)
//   A, B   operands (captured together with start)
//   busy   operation in progress
//   done   one-cycle pulse when Sum/Cout/Ovf take a new result
//   Sum    registered result, held until the next completion
//   Cout   carry out of the MSB (for subtraction, 1 means no borrow)
//   Ovf    signed overflow of the last completed operation
//
// Modports
//   master  requester side (drives start/sub/A/B)
//   slave   the arithmetic unit
// -----------------------------------------------------------------------------
interface serial_addsub32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    modport master (
        output start, sub, A, B,
        input  busy, done, Sum, Cout, Ovf
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, Sum, Cout, Ovf
    );
endinterface

// File: rtl/serial_addsub32.sv
// -----------------------------------------------------------------------------
// serial_addsub32
//
// Bit-serial two's-complement adder/subtractor. A single full-adder equation
// is applied one bit per clock, LSB first, over WIDTH cycles. Subtraction is
// done as A + ~B + 1: B is inverted on capture and the carry is seeded with 1.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; aborts any operation in progress
//   bus   serial_addsub32_if.slave (start/sub/A/B in, busy/done/Sum/Cout/Ovf out)
//
// Timing: start sampled at edge k -> bits processed on edges k+1..k+WIDTH,
// result registered and done pulsed at edge k+WIDTH.
// -----------------------------------------------------------------------------
module serial_addsub32 #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    serial_addsub32_if.slave    bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic s_bit;
    logic c_next;
    logic last_bit;

    // One full-adder slice operating on the current LSBs.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the values from before the clock edge, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B ^ {WIDTH{bus.sub}};
                        carry <= bus.sub;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= {s_bit, r_sh[WIDTH-1:1]};
                    carry <= c_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // While on the MSB, 'carry' is the carry into the MSB,
                        // so overflow is simply carry-in XOR carry-out here.
                        sum_q  <= {s_bit, r_sh[WIDTH-1:1]};
                        cout_q <= c_next;
                        ovf_q  <= carry ^ c_next;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;

endmodule
